// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  localparam int unsigned REG_ADDR_W_DEF        = 5;
  localparam int unsigned LOAD_STALL_CYCLES_DEF = 1;
  localparam int unsigned BRANCH_PENALTY_DEF    = 1;

  // rem only ever holds (max - 1), so $clog2(max) bits suffice; keep at least one bit.
  function automatic int unsigned rem_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned REM_W_DEF = rem_width(LOAD_STALL_CYCLES_DEF, BRANCH_PENALTY_DEF);

endpackage

// File: rtl/sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ID-stage hazard controller: multi-cycle load-use stall, branch flush penalty,
// EX-busy freeze, and saturating stall/flush performance counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
  parameter int unsigned BRANCH_PENALTY    = BRANCH_PENALTY_DEF,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  branch_taken,
  input  logic                  ex_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned     REM_W  = rem_width(LOAD_STALL_CYCLES, BRANCH_PENALTY);
  localparam logic [REM_W-1:0] LD_REM = REM_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [REM_W-1:0] BR_REM = REM_W'(BRANCH_PENALTY - 1);

  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             haz;
  logic             stall_inc;
  logic             flush_inc;

  always_comb begin
    haz = id_ex_mem_read && (id_ex_rd != '0) &&
          ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
           (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    state_d      = state_q;
    rem_d        = rem_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (ex_busy) begin
      // Freeze: state/rem hold, so an interrupted stall resumes where it left off.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      stall_inc   = 1'b1;
    end else if (branch_taken) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      flush_inc    = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d = BR_FLUSH;
        rem_d   = BR_REM;
      end else begin
        state_d = IDLE;
        rem_d   = '0;
      end
    end else begin
      case (state_q)
        BR_FLUSH: begin
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
        LD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
        default: begin
          if (haz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LD_STALL;
              rem_d   = LD_REM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus pushes expected strobes/counters from a cycle-count model,
// a negedge monitor pops and compares. A second 3-bit-counter instance exercises saturation.
module tb_pipeline_hazard_controller;

  localparam int unsigned LSC = 2;
  localparam int unsigned BP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rd = '0, rs1 = '0, rs2 = '0;
  logic       uses1 = 1'b0, uses2 = 1'b0, br = 1'b0, busy = 1'b0;

  logic        pc_w, ifid_w, idex_w, bub, fl;
  logic [31:0] st_cnt, fl_cnt;
  logic        s_pc_w, s_ifid_w, s_idex_w, s_bub, s_fl;
  logic [2:0]  s_st_cnt, s_fl_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC), .BRANCH_PENALTY(BP), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rd(ex_rd),
    .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(uses1), .id_uses_rs2(uses2),
    .branch_taken(br), .ex_busy(busy), .pc_write(pc_w), .if_id_write(ifid_w),
    .id_ex_write(idex_w), .id_ex_bubble(bub), .if_id_flush(fl),
    .stall_cnt(st_cnt), .flush_cnt(fl_cnt)
  );

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC), .BRANCH_PENALTY(BP), .CNT_W(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rd(ex_rd),
    .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(uses1), .id_uses_rs2(uses2),
    .branch_taken(br), .ex_busy(busy), .pc_write(s_pc_w), .if_id_write(s_ifid_w),
    .id_ex_write(s_idex_w), .id_ex_bubble(s_bub), .if_id_flush(s_fl),
    .stall_cnt(s_st_cnt), .flush_cnt(s_fl_cnt)
  );

  typedef struct {
    logic [4:0]      strb;  // {pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush}
    longint unsigned st;
    longint unsigned fl;
    int unsigned     cyc;
  } exp_t;

  exp_t sbq[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  int unsigned     ld_left = 0;
  int unsigned     br_left = 0;
  longint unsigned st_n = 0;
  longint unsigned fl_n = 0;
  int unsigned     cyc_no = 0;

  function automatic longint unsigned sat7(input longint unsigned v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic check(input string name, input int unsigned cyc,
                       input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // One clock cycle of stimulus; expected outputs derived from remaining-cycle counts.
  task automatic step(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] a,
                      input logic [4:0] b, input bit u1, input bit u2, input bit bt, input bit bz);
    exp_t e;
    bit   haz;
    @(posedge clk);
    #1;
    rst = r; mem_read = mr; ex_rd = rd; rs1 = a; rs2 = b;
    uses1 = u1; uses2 = u2; br = bt; busy = bz;
    cyc_no++;
    e.cyc = cyc_no;
    haz = mr && (rd != 0) && ((u1 && a == rd) || (u2 && b == rd));
    if (r) begin
      ld_left = 0; br_left = 0; st_n = 0; fl_n = 0;
      e.strb = 5'b00111;
      e.st = 0; e.fl = 0;
    end else begin
      e.st = st_n; e.fl = fl_n;
      if (bz) begin
        e.strb = 5'b00000; st_n++;
      end else if (bt) begin
        e.strb = 5'b11111; fl_n++; ld_left = 0; br_left = BP - 1;
      end else if (br_left > 0) begin
        e.strb = 5'b11101; fl_n++; br_left--;
      end else if (ld_left > 0) begin
        e.strb = 5'b00110; st_n++; ld_left--;
      end else if (haz) begin
        e.strb = 5'b00110; st_n++; ld_left = LSC - 1;
      end else begin
        e.strb = 5'b11100;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("strobes", e.cyc, {pc_w, ifid_w, idex_w, bub, fl}, e.strb);
        check("stall_cnt", e.cyc, st_cnt, e.st);
        check("flush_cnt", e.cyc, fl_cnt, e.fl);
        check("sat_strobes", e.cyc, {s_pc_w, s_ifid_w, s_idex_w, s_bub, s_fl}, e.strb);
        check("sat_stall_cnt", e.cyc, s_st_cnt, sat7(e.st));
        check("sat_flush_cnt", e.cyc, s_fl_cnt, sat7(e.fl));
      end
    end
  end

  initial begin : stimulus
    int unsigned drain;
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1, two-cycle stall
    step(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0);
    idle(3);
    // x0 never stalls; unused rs2 never stalls
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    step(0, 1, 5'd4, 5'd0, 5'd4, 0, 0, 0, 0);
    step(0, 1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 0);
    idle(3);
    // single taken branch, three flush cycles
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(4);
    // branch beats a simultaneous hazard
    step(0, 1, 5'd12, 5'd12, 5'd0, 1, 0, 1, 0);
    idle(4);
    // branch during the second stall cycle cancels the stall
    step(0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(4);
    // ex_busy freezes LD_STALL for four cycles, then the stall resumes
    step(0, 1, 5'd9, 5'd0, 5'd9, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    idle(3);
    // async reset in the middle of BR_FLUSH
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(2);
    // randomized traffic; small register range keeps hazards frequent
    for (int unsigned i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 60,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 10);
    end
    idle(2);
    drain = 0;
    while (sbq.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
